// File: rtl/approx_err_monitor.sv
// Error monitor for the registered approximate adder: pairs each SUM with the
// operands from the previous cycle and publishes per-window error statistics.
module approx_err_monitor #(
  parameter int DW       = 16,
  parameter int WIN_LOG2 = 8,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [DW-1:0]       A,
  input  logic [DW-1:0]       B,
  input  logic [DW:0]         SUM,
  output logic                stat_valid,
  input  logic                stat_ready,
  output logic [WIN_LOG2:0]   err_cnt,
  output logic [ACC_W-1:0]    err_sum,
  output logic [DW:0]         err_max,
  output logic                overrun
);

  // Saturating add runs one bit wider than the larger of accumulator and diff.
  localparam int SW = ((ACC_W > DW + 1) ? ACC_W : DW + 1) + 1;
  localparam logic [ACC_W-1:0]    ACC_MAX   = '1;
  localparam logic [WIN_LOG2-1:0] SAMP_LAST = '1;
  localparam logic [WIN_LOG2-1:0] SAMP_ONE  = 1;

  logic [DW-1:0]       s1_a_q, s1_b_q;
  logic                s1_v_q;
  logic [WIN_LOG2-1:0] samp_q, samp_d;
  logic [WIN_LOG2:0]   cnt_acc_q, cnt_acc_d;
  logic [ACC_W-1:0]    sum_acc_q, sum_acc_d;
  logic [DW:0]         max_acc_q, max_acc_d;
  logic                stat_valid_q, stat_valid_d;
  logic [WIN_LOG2:0]   err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0]    err_sum_q, err_sum_d;
  logic [DW:0]         err_max_q, err_max_d;
  logic                overrun_q, overrun_d;

  logic [DW:0]         exact, diff, max_nxt;
  logic                mis, win_end;
  logic [SW-1:0]       sum_ext;
  logic [ACC_W-1:0]    sum_nxt;
  logic [WIN_LOG2:0]   cnt_nxt;

  always_comb begin
    exact   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff    = (exact >= SUM) ? (exact - SUM) : (SUM - exact);
    mis     = |diff;
    cnt_nxt = cnt_acc_q + {{WIN_LOG2{1'b0}}, mis};
    sum_ext = SW'(sum_acc_q) + SW'(diff);
    sum_nxt = (sum_ext > SW'(ACC_MAX)) ? ACC_MAX : sum_ext[ACC_W-1:0];
    max_nxt = (diff > max_acc_q) ? diff : max_acc_q;
    win_end = s1_v_q && (samp_q == SAMP_LAST);

    samp_d       = samp_q;
    cnt_acc_d    = cnt_acc_q;
    sum_acc_d    = sum_acc_q;
    max_acc_d    = max_acc_q;
    stat_valid_d = stat_valid_q;
    err_cnt_d    = err_cnt_q;
    err_sum_d    = err_sum_q;
    err_max_d    = err_max_q;
    overrun_d    = overrun_q;

    if (s1_v_q) begin
      samp_d    = samp_q + SAMP_ONE;
      cnt_acc_d = cnt_nxt;
      sum_acc_d = sum_nxt;
      max_acc_d = max_nxt;
    end

    // A window end always publishes; an accept on the same edge is absorbed.
    if (win_end) begin
      samp_d       = '0;
      cnt_acc_d    = '0;
      sum_acc_d    = '0;
      max_acc_d    = '0;
      err_cnt_d    = cnt_nxt;
      err_sum_d    = sum_nxt;
      err_max_d    = max_nxt;
      stat_valid_d = 1'b1;
      overrun_d    = overrun_q | (stat_valid_q & ~stat_ready);
    end else if (stat_valid_q && stat_ready) begin
      stat_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_v_q       <= 1'b0;
      samp_q       <= '0;
      cnt_acc_q    <= '0;
      sum_acc_q    <= '0;
      max_acc_q    <= '0;
      stat_valid_q <= 1'b0;
      err_cnt_q    <= '0;
      err_sum_q    <= '0;
      err_max_q    <= '0;
      overrun_q    <= 1'b0;
    end else if (clr) begin
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_v_q       <= 1'b0;
      samp_q       <= '0;
      cnt_acc_q    <= '0;
      sum_acc_q    <= '0;
      max_acc_q    <= '0;
      stat_valid_q <= 1'b0;
      err_cnt_q    <= '0;
      err_sum_q    <= '0;
      err_max_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      s1_a_q       <= A;
      s1_b_q       <= B;
      s1_v_q       <= in_valid;
      samp_q       <= samp_d;
      cnt_acc_q    <= cnt_acc_d;
      sum_acc_q    <= sum_acc_d;
      max_acc_q    <= max_acc_d;
      stat_valid_q <= stat_valid_d;
      err_cnt_q    <= err_cnt_d;
      err_sum_q    <= err_sum_d;
      err_max_q    <= err_max_d;
      overrun_q    <= overrun_d;
    end
  end

  assign stat_valid = stat_valid_q;
  assign err_cnt    = err_cnt_q;
  assign err_sum    = err_sum_q;
  assign err_max    = err_max_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor with 4-sample windows; a second
// instance with a 10-bit accumulator covers saturation on the same stimulus.
module tb_approx_err_monitor;

  localparam int DW = 16;
  localparam int WL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] A = '0, B = '0;
  logic [DW:0]   SUM = '0;
  logic          stat_ready = 1'b0;

  logic          stat_valid, overrun;
  logic [WL:0]   err_cnt;
  logic [31:0]   err_sum;
  logic [DW:0]   err_max;

  logic          s_stat_valid, s_overrun;
  logic [WL:0]   s_err_cnt;
  logic [9:0]    s_err_sum;
  logic [DW:0]   s_err_max;

  logic [DW:0]   pend_sum = '0;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  approx_err_monitor #(.DW(DW), .WIN_LOG2(WL), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A), .B(B), .SUM(SUM),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .err_cnt(err_cnt),
    .err_sum(err_sum), .err_max(err_max), .overrun(overrun)
  );

  approx_err_monitor #(.DW(DW), .WIN_LOG2(WL), .ACC_W(10)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A), .B(B), .SUM(SUM),
    .stat_valid(s_stat_valid), .stat_ready(stat_ready), .err_cnt(s_err_cnt),
    .err_sum(s_err_sum), .err_max(s_err_max), .overrun(s_overrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: present operands now, SUM for the previous cycle's operands.
  task automatic cyc(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [DW:0] s);
    in_valid = v;
    A        = a;
    B        = b;
    SUM      = pend_sum;
    pend_sum = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [WL:0] c,
                           input logic [31:0] s, input logic [DW:0] m, input logic o);
    check({tag, ".valid"},   stat_valid, v);
    check({tag, ".cnt"},     err_cnt, c);
    check({tag, ".sum"},     err_sum, s);
    check({tag, ".max"},     err_max, m);
    check({tag, ".overrun"}, overrun, o);
  endtask

  initial begin
    #1;
    check_out("reset", 1'b0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // exact window, consumer always ready
    stat_ready = 1'b1;
    cyc(1, 16'h0002, 16'h0000, 17'h00002);
    cyc(1, 16'h00FF, 16'h0001, 17'h00100);
    cyc(1, 16'h1234, 16'h0100, 17'h01334);
    cyc(1, 16'h0000, 16'h0000, 17'h00000);
    check("exact.pre_valid", stat_valid, 1'b0);
    idle();
    check_out("exact", 1'b1, 0, 0, 0, 1'b0);
    idle();
    check("exact.pulse_end", stat_valid, 1'b0);

    // mixed errors, SUM above and below exact
    cyc(1, 16'h0001, 16'h0000, 17'h00101);
    cyc(1, 16'h00FE, 16'h0002, 17'h00000);
    cyc(1, 16'h0003, 16'h0000, 17'h00103);
    cyc(1, 16'h0004, 16'h0004, 17'h00008);
    idle();
    check_out("mixed", 1'b1, 3, 32'h300, 17'h100, 1'b0);
    idle();
    check("mixed.accepted", stat_valid, 1'b0);
    check("mixed.hold_cnt", err_cnt, 3);

    // gaps and backpressure
    stat_ready = 1'b0;
    cyc(1, 16'h0010, 16'h0000, 17'h00011);
    idle();
    cyc(1, 16'h0020, 16'h0000, 17'h00020);
    idle();
    idle();
    cyc(1, 16'h0000, 16'h0000, 17'h00005);
    cyc(1, 16'h0001, 16'h0001, 17'h00002);
    idle();
    check_out("gaps", 1'b1, 2, 6, 5, 1'b0);
    repeat (3) idle();
    check_out("stall", 1'b1, 2, 6, 5, 1'b0);
    cyc(1, 16'h0000, 16'h0000, 17'h00000);
    cyc(1, 16'h0007, 16'h0000, 17'h00000);
    cyc(1, 16'h0000, 16'h0000, 17'h00000);
    cyc(1, 16'h0000, 16'h0000, 17'h00000);
    idle();
    check_out("overrun", 1'b1, 1, 7, 7, 1'b1);
    clr = 1'b1;
    idle();
    clr = 1'b0;
    check_out("clr", 1'b0, 0, 0, 0, 1'b0);

    // accept lands on the same edge as the next window end
    cyc(1, 16'h0001, 16'h0000, 17'h00001);
    cyc(1, 16'h0002, 16'h0000, 17'h00002);
    cyc(1, 16'h0003, 16'h0000, 17'h00003);
    cyc(1, 16'h0004, 16'h0000, 17'h00005);
    idle();
    check_out("w5", 1'b1, 1, 1, 1, 1'b0);
    cyc(1, 16'h0000, 16'h0000, 17'h00002);
    cyc(1, 16'h0000, 16'h0000, 17'h00002);
    cyc(1, 16'h0000, 16'h0000, 17'h00000);
    cyc(1, 16'h0000, 16'h0000, 17'h00000);
    stat_ready = 1'b1;
    idle();
    check_out("accept_at_end", 1'b1, 2, 4, 2, 1'b0);
    idle();
    check("accept_at_end.drain", stat_valid, 1'b0);

    // saturation on the 10-bit accumulator instance
    repeat (4) cyc(1, 16'h0000, 16'h0000, 17'h1FFFF);
    idle();
    check_out("sat_wide", 1'b1, 4, 32'h7FFFC, 17'h1FFFF, 1'b0);
    check("sat.valid", s_stat_valid, 1'b1);
    check("sat.sum", s_err_sum, 10'h3FF);
    check("sat.max", s_err_max, 17'h1FFFF);

    // async reset mid-window
    stat_ready = 1'b0;
    cyc(1, 16'h0005, 16'h0000, 17'h00006);
    cyc(1, 16'h0005, 16'h0000, 17'h00006);
    #3 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    cyc(1, 16'h0001, 16'h0000, 17'h00001);
    cyc(1, 16'h0001, 16'h0000, 17'h00003);
    cyc(1, 16'h0001, 16'h0000, 17'h00001);
    check("post_rst.no_early", stat_valid, 1'b0);
    cyc(1, 16'h0001, 16'h0000, 17'h00001);
    idle();
    check_out("post_rst", 1'b1, 1, 2, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
